// File: rtl/gpu_pkg.sv
// gpu_pkg
// Shared types for the core pipeline: the scheduler's core state encoding, the fetcher
// handshake state encoding, and a helper that sizes the instruction cache index.
// Optional feature macro used by the fetch stage: ICACHE_EN.
package gpu_pkg;

    typedef enum logic [2:0] {
        CORE_IDLE    = 3'b000,
        CORE_FETCH   = 3'b001,
        CORE_DECODE  = 3'b010,
        CORE_REQUEST = 3'b011,
        CORE_WAIT    = 3'b100,
        CORE_EXECUTE = 3'b101,
        CORE_UPDATE  = 3'b110,
        CORE_DONE    = 3'b111
    } core_state_t;

    typedef enum logic [2:0] {
        FETCH_IDLE     = 3'b000,
        FETCH_FETCHING = 3'b001,
        FETCH_FETCHED  = 3'b010
    } fetcher_state_t;

    // Number of index bits for a direct-mapped cache with the given line count.
    // Line counts below 2 are clamped so the index field never collapses to zero width.
    function automatic int icacheIdxBits(input int lines);
        return (lines < 2) ? 1 : $clog2(lines);
    endfunction

    localparam int ICACHE_IDX_BITS = icacheIdxBits(4);

endpackage

// File: rtl/fetch_icache.sv
// fetch_icache
// Direct-mapped instruction cache for the fetch stage (only instantiated when ICACHE_EN is defined).
// Lookup is combinational on lookup_addr_i; fills and flushes take effect on the next clock edge.
// Ports:
//   clk, reset        clock and asynchronous active-high reset (clears valid bits)
//   flush_i           invalidate every line; wins over a coincident fill
//   lookup_addr_i     address being looked up
//   hit_o             line valid and tag matches
//   hit_data_o        data stored in the indexed line
//   fill_en_i         write fill_data_i into the line selected by fill_addr_i
//   fill_addr_i       address of the returning instruction
//   fill_data_i       instruction returned by program memory
module fetch_icache
    import gpu_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 16,
    parameter int LINES     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush_i,
    input  logic [ADDR_BITS-1:0] lookup_addr_i,
    output logic                 hit_o,
    output logic [DATA_BITS-1:0] hit_data_o,
    input  logic                 fill_en_i,
    input  logic [ADDR_BITS-1:0] fill_addr_i,
    input  logic [DATA_BITS-1:0] fill_data_i
);

    localparam int IDX_BITS = icacheIdxBits(LINES);
    localparam int TAG_BITS = ADDR_BITS - IDX_BITS;

    logic [LINES-1:0]     valid_q;
    logic [TAG_BITS-1:0]  tag_q  [LINES];
    logic [DATA_BITS-1:0] data_q [LINES];

    logic [IDX_BITS-1:0] lookupIdx;
    logic [TAG_BITS-1:0] lookupTag;
    logic [IDX_BITS-1:0] fillIdx;

    assign lookupIdx  = lookup_addr_i[IDX_BITS-1:0];
    assign lookupTag  = lookup_addr_i[ADDR_BITS-1:IDX_BITS];
    assign fillIdx    = fill_addr_i[IDX_BITS-1:0];
    assign hit_o      = valid_q[lookupIdx] && (tag_q[lookupIdx] == lookupTag);
    assign hit_data_o = data_q[lookupIdx];

    // Valid bits: flush takes priority so a line filled in the flush cycle stays invalid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
        end else if (fill_en_i) begin
            valid_q[fillIdx] <= 1'b1;
        end
    end

    // Tag and data storage need no reset; they are only trusted behind a valid bit.
    always_ff @(posedge clk) begin
        if (fill_en_i) begin
            tag_q[fillIdx]  <= fill_addr_i[ADDR_BITS-1:IDX_BITS];
            data_q[fillIdx] <= fill_data_i;
        end
    end

endmodule

// File: rtl/instruction_fetcher.sv
// instruction_fetcher
// Per-core fetch stage. When the core is in FETCH it obtains the instruction at current_pc,
// either from the optional instruction cache (one-cycle hit) or from the program-memory
// controller via a valid/ready handshake, and holds it for the decoder.
// Optional feature: define ICACHE_EN to include the direct-mapped cache (fetch_icache).
// Without it every fetch goes to memory and icache_flush has no effect.
// Ports:
//   clk, reset                     clock and asynchronous active-high reset
//   enable                         core has a live block
//   core_state                     scheduler state of the core
//   current_pc                     address to fetch
//   icache_flush                   invalidate all cache lines
//   mem_read_valid/address         request to program memory, held until mem_read_ready
//   mem_read_ready/data            one-cycle response strobe and instruction
//   fetcher_state                  IDLE / FETCHING / FETCHED
//   instruction                    last fetched instruction
module instruction_fetcher
    import gpu_pkg::*;
#(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16,
    parameter int ICACHE_LINES          = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic [2:0]                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    input  logic                             icache_flush,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction
);

    fetcher_state_t                   state_q, state_d;
    logic                             valid_q, valid_d;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] addr_q,  addr_d;
    logic [PROGRAM_MEM_DATA_BITS-1:0] instr_q, instr_d;

    logic                             cacheHit;
    logic [PROGRAM_MEM_DATA_BITS-1:0] cacheData;

`ifdef ICACHE_EN
    logic cacheFill;

    // The line is filled from the latched request address, not current_pc, since the PC
    // may have moved while the request was outstanding.
    assign cacheFill = (state_q == FETCH_FETCHING) && mem_read_ready;

    fetch_icache #(
        .ADDR_BITS (PROGRAM_MEM_ADDR_BITS),
        .DATA_BITS (PROGRAM_MEM_DATA_BITS),
        .LINES     (ICACHE_LINES)
    ) uIcache (
        .clk           (clk),
        .reset         (reset),
        .flush_i       (icache_flush),
        .lookup_addr_i (current_pc),
        .hit_o         (cacheHit),
        .hit_data_o    (cacheData),
        .fill_en_i     (cacheFill),
        .fill_addr_i   (addr_q),
        .fill_data_i   (mem_read_data)
    );
`else
    logic unusedFlush;

    assign unusedFlush = icache_flush;
    assign cacheHit    = 1'b0;
    assign cacheData   = '0;
`endif

    // State and output registers; reset drops any outstanding request immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH_IDLE;
            valid_q <= 1'b0;
            addr_q  <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
        end
    end

    // Next-state logic. FETCHING deliberately ignores enable so a response is never lost.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        case (state_q)
            FETCH_IDLE: begin
                if (enable && (core_state == CORE_FETCH)) begin
                    if (cacheHit) begin
                        instr_d = cacheData;
                        state_d = FETCH_FETCHED;
                    end else begin
                        valid_d = 1'b1;
                        addr_d  = current_pc;
                        state_d = FETCH_FETCHING;
                    end
                end
            end
            FETCH_FETCHING: begin
                if (mem_read_ready) begin
                    valid_d = 1'b0;
                    instr_d = mem_read_data;
                    state_d = FETCH_FETCHED;
                end
            end
            FETCH_FETCHED: begin
                if (enable && (core_state == CORE_DECODE)) begin
                    state_d = FETCH_IDLE;
                end
            end
            default: begin
                state_d = FETCH_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    assign fetcher_state    = state_q;
    assign mem_read_valid   = valid_q;
    assign mem_read_address = addr_q;
    assign instruction      = instr_q;

endmodule
